// File: rtl/jtag_hex_pkg.sv
// Shared ASCII constants, parser states and hex-digit decoding for the
// JTAG-UART hex line receiver.
package jtag_hex_pkg;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] HT = 8'h09;

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, HOLD} state_t;

  // Returns {is_digit, nibble}; nibble is zero for non-hex bytes.
  function automatic logic [4:0] hex_nibble(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, 4'(b - 8'h30)};
    end else if (b >= 8'h41 && b <= 8'h46) begin
      r = {1'b1, 4'(b - 8'h37)};
    end else if (b >= 8'h61 && b <= 8'h66) begin
      r = {1'b1, 4'(b - 8'h57)};
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_char_class.sv
// Combinational classifier for one received byte: hex digit, line
// terminator or whitespace separator; anything else is illegal.
module hex_char_class
  import jtag_hex_pkg::*;
(
  input  logic [7:0] data,
  output logic       is_digit,
  output logic       is_term,
  output logic       is_sep,
  output logic [3:0] nibble
);

  always_comb begin
    {is_digit, nibble} = hex_nibble(data);
    is_term = (data == CR) || (data == LF);
    is_sep  = (data == SP) || (data == HT);
  end

endmodule

// File: rtl/jtag_hex_rx.sv
// Parses CR/LF-terminated ASCII hex lines from the JTAG UART into words on a
// valid/ready port. Defining JTAG_HEX_RX_ECHO_EN adds a 1-entry byte echo port.
module jtag_hex_rx
  import jtag_hex_pkg::*;
#(
  parameter int WORD_W   = 18,
  parameter int ERRCNT_W = 8
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [WORD_W-1:0]   word_o,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                err_pulse,
  output logic [ERRCNT_W-1:0] err_count,
  output logic                busy
`ifdef JTAG_HEX_RX_ECHO_EN
  ,
  output logic [7:0]          echo_data,
  output logic                echo_valid,
  input  logic                echo_ready
`endif
);

  localparam int MAX_DIGITS = (WORD_W + 3) / 4;
  localparam int ACC_W      = MAX_DIGITS * 4;
  localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

  state_t           state;
  state_t           cur;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             started;
  logic             is_digit;
  logic             is_term;
  logic             is_sep;
  logic [3:0]       nibble;
  logic             handshake;
  logic             fsm_ready;
  logic             take;
  logic             overflow;
  logic             bad_end;

  hex_char_class u_class (
    .data     (rx_data),
    .is_digit (is_digit),
    .is_term  (is_term),
    .is_sep   (is_sep),
    .nibble   (nibble)
  );

  // Bits above WORD_W only exist when WORD_W is not a multiple of 4.
  if (ACC_W > WORD_W) begin : g_ovf
    assign overflow = |acc[ACC_W-1:WORD_W];
  end else begin : g_no_ovf
    assign overflow = 1'b0;
  end

  assign handshake = word_valid && word_ready;
  // Releasing a held word frees the parser in the same cycle, so the byte
  // accepted alongside the handshake is decoded as if already in IDLE.
  assign fsm_ready = started && ((state != HOLD) || handshake);
  assign cur       = (state == HOLD && handshake) ? IDLE : state;

`ifdef JTAG_HEX_RX_ECHO_EN
  assign rx_ready = fsm_ready && (!echo_valid || echo_ready);
`else
  assign rx_ready = fsm_ready;
`endif

  assign take    = rx_valid && rx_ready;
  assign bad_end = take && is_term &&
                   ((cur == DISCARD) || (cur == ACCUM && overflow));
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      started    <= 1'b0;
      word_o     <= '0;
      word_valid <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
    end else begin
      started   <= 1'b1;
      err_pulse <= 1'b0;

      if (handshake) begin
        word_valid <= 1'b0;
        acc        <= '0;
        cnt        <= '0;
        state      <= IDLE;
      end

      if (bad_end) begin
        err_pulse <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
      end

      if (take && !is_sep) begin
        case (cur)
          IDLE: begin
            if (is_digit) begin
              acc   <= ACC_W'(nibble);
              cnt   <= CNT_W'(1);
              state <= ACCUM;
            end else if (!is_term) begin
              state <= DISCARD;
            end
          end
          ACCUM: begin
            if (is_digit) begin
              if (cnt == CNT_W'(MAX_DIGITS)) begin
                state <= DISCARD;
              end else begin
                acc <= ACC_W'({acc, nibble});
                cnt <= cnt + 1'b1;
              end
            end else if (is_term) begin
              if (overflow) begin
                acc   <= '0;
                cnt   <= '0;
                state <= IDLE;
              end else begin
                word_o     <= acc[WORD_W-1:0];
                word_valid <= 1'b1;
                state      <= HOLD;
              end
            end else begin
              state <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_term) begin
              acc   <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef JTAG_HEX_RX_ECHO_EN
  // rx_ready already waits for a free slot, so a new byte never overwrites
  // one the sink has not taken.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      echo_data  <= '0;
      echo_valid <= 1'b0;
    end else if (take) begin
      echo_data  <= rx_data;
      echo_valid <= 1'b1;
    end else if (echo_ready) begin
      echo_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_hex_rx.sv
// Randomised self-checking bench for jtag_hex_rx: a line-level model predicts
// words and bad-line events from the byte stream sent.
module tb_jtag_hex_rx;

  localparam int WORD_W   = 18;
  localparam int ERRCNT_W = 8;

  logic                clock = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic                rx_ready;
  logic [WORD_W-1:0]   word_o;
  logic                word_valid;
  logic                word_ready = 1'b0;
  logic                err_pulse;
  logic [ERRCNT_W-1:0] err_count;
  logic                busy;
`ifdef JTAG_HEX_RX_ECHO_EN
  logic [7:0]          echo_data;
  logic                echo_valid;
  logic                echo_ready = 1'b0;
`endif

  jtag_hex_rx #(.WORD_W(WORD_W), .ERRCNT_W(ERRCNT_W)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .word_o     (word_o),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .busy       (busy)
`ifdef JTAG_HEX_RX_ECHO_EN
    ,
    .echo_data  (echo_data),
    .echo_valid (echo_valid),
    .echo_ready (echo_ready)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_err;
    int val;
    int cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] echo_q[$];

  int checks = 0;
  int errors = 0;

  // Line-level reference model state
  int     m_digits = 0;
  longint m_val = 0;
  bit     m_bad = 0;
  bit     m_used = 0;
  int     m_errs = 0;

  // Monitor history from the previous sample point
  bit                prev_wv = 0;
  bit                prev_hs = 0;
  bit                prev_err = 0;
  bit                prev_term_acc = 0;
  logic [WORD_W-1:0] held_word = '0;
  int                wv_run = 0;
  int                stall_len = 0;
  int                echo_hold = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int hexVal(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  function automatic bit isTerm(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic bit isSep(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h09);
  endfunction

  // A finished line yields a word only if it holds nothing but 1..5 hex
  // digits whose value fits in WORD_W bits; blank lines yield nothing.
  task automatic modelByte(input logic [7:0] b);
    ev_t e;
    if (isSep(b)) return;
    if (isTerm(b)) begin
      if (m_used) begin
        if (m_bad || m_digits > 5 || m_val >= (64'd1 << WORD_W)) begin
          m_errs++;
          e = '{is_err: 1'b1, val: 0, cnt: (m_errs > 255) ? 255 : m_errs};
        end else begin
          e = '{is_err: 1'b0, val: int'(m_val), cnt: 0};
        end
        exp_q.push_back(e);
      end
      m_digits = 0;
      m_val    = 0;
      m_bad    = 0;
      m_used   = 0;
    end else if (hexVal(b) >= 0) begin
      m_used = 1;
      m_digits++;
      if (m_digits <= 5) m_val = m_val * 16 + hexVal(b);
    end else begin
      m_used = 1;
      m_bad  = 1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    tx_q.push_back(b);
    modelByte(b);
  endtask

  task automatic sendText(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  task automatic popExpect(input bit is_err, input logic [31:0] val);
    ev_t e;
    checkOutput("event_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("event_kind", 32'(is_err), 32'(e.is_err));
      if (is_err && e.is_err) checkOutput("err_count", 32'(err_count), e.cnt);
      if (!is_err && !e.is_err) checkOutput("word_value", val, e.val);
    end
  endtask

  // One clock: drive inputs after the falling edge, then sample settled
  // outputs and score what the next rising edge will commit.
  task automatic applyStimulus();
    @(negedge clock);
    if (stall_len > 0) word_ready = word_valid && (wv_run >= stall_len);
    else word_ready = ($urandom_range(0, 3) != 0);
    if (tx_q.size() > 0 && $urandom_range(0, 4) != 0) begin
      rx_valid = 1'b1;
      rx_data  = tx_q[0];
    end else begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
`ifdef JTAG_HEX_RX_ECHO_EN
    if (echo_hold > 0) begin
      echo_ready = 1'b0;
      if (echo_valid) echo_hold--;
    end else begin
      echo_ready = ($urandom_range(0, 2) != 0);
    end
`endif
    #1;
    if (word_valid && !prev_wv) begin
      checkOutput("wv_latency", 32'(prev_term_acc), 1);
      checkOutput("err_with_word", 32'(err_pulse), 0);
      popExpect(1'b0, 32'(word_o));
    end
    if (prev_wv && !prev_hs) checkOutput("wv_held", 32'(word_valid), 1);
    if (word_valid && prev_wv) checkOutput("word_stable", 32'(word_o), 32'(held_word));
    if (word_valid && !word_ready) checkOutput("hold_backpressure", 32'(rx_ready), 0);
    if (err_pulse) begin
      checkOutput("err_single", 32'(prev_err), 0);
      popExpect(1'b1, 0);
    end
`ifdef JTAG_HEX_RX_ECHO_EN
    if (echo_valid && echo_ready) begin
      checkOutput("echo_present", 32'(echo_q.size() != 0), 1);
      if (echo_q.size() != 0) checkOutput("echo_data", 32'(echo_data), 32'(echo_q.pop_front()));
    end
    if (echo_valid && !echo_ready) checkOutput("echo_backpressure", 32'(rx_ready), 0);
    if (rx_valid && rx_ready) echo_q.push_back(rx_data);
`endif
    prev_term_acc = rx_valid && rx_ready && isTerm(rx_data);
    if (rx_valid && rx_ready) void'(tx_q.pop_front());
    prev_wv   = word_valid;
    prev_hs   = word_valid && word_ready;
    prev_err  = err_pulse;
    held_word = word_o;
    wv_run    = (word_valid && !word_ready) ? wv_run + 1 : 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0 || word_valid) && n < 5000) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_done", 32'(n < 5000), 1);
  endtask

  task automatic doReset();
    @(negedge clock);
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    word_ready = 1'b0;
`ifdef JTAG_HEX_RX_ECHO_EN
    echo_ready = 1'b0;
    echo_hold  = 0;
`endif
    #1;
    checkOutput("rst_word_valid", 32'(word_valid), 0);
    checkOutput("rst_word_o", 32'(word_o), 0);
    checkOutput("rst_err_pulse", 32'(err_pulse), 0);
    checkOutput("rst_err_count", 32'(err_count), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_rx_ready", 32'(rx_ready), 0);
    tx_q.delete();
    exp_q.delete();
    echo_q.delete();
    m_digits = 0; m_val = 0; m_bad = 0; m_used = 0; m_errs = 0;
    prev_wv = 0; prev_hs = 0; prev_err = 0; prev_term_acc = 0; wv_run = 0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_ready_first", 32'(rx_ready), 0);
    @(negedge clock);
    #1;
    checkOutput("rst_ready_idle", 32'(rx_ready), 1);
  endtask

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    if ($urandom_range(0, 1) == 0) return 8'h41 + 8'(n) - 8'd10;
    return 8'h61 + 8'(n) - 8'd10;
  endfunction

  task automatic emitDigits(input logic [23:0] v, input int nd);
    for (int i = nd - 1; i >= 0; i--) begin
      if ($urandom_range(0, 5) == 0) sendByte(($urandom_range(0, 1) == 0) ? 8'h20 : 8'h09);
      sendByte(hexChar(v[4*i +: 4]));
    end
  endtask

  task automatic randomLine();
    int          kind;
    int          nd;
    logic [23:0] v;
    logic [7:0]  b;
    kind = $urandom_range(0, 9);
    v    = 24'($urandom);
    case (kind)
      5: begin
        v[19:16] = 4'($urandom_range(4, 15));
        emitDigits(v, 5);
      end
      6: emitDigits(v, $urandom_range(6, 6));
      7: begin
        emitDigits(v, $urandom_range(0, 3));
        do b = 8'($urandom); while (hexVal(b) >= 0 || isTerm(b) || isSep(b));
        sendByte(b);
        emitDigits(24'($urandom), $urandom_range(0, 2));
      end
      8: if ($urandom_range(0, 1) == 0) sendByte(8'h20);
      default: begin
        nd = $urandom_range(1, 5);
        v  = v & ((24'd1 << (4 * nd)) - 24'd1);
        if (nd == 5) v[19:18] = 2'b00;
        emitDigits(v, nd);
      end
    endcase
    if (kind == 9) begin
      sendByte(8'h0D);
      sendByte(8'h0A);
    end else begin
      sendByte(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
    end
  endtask

  initial begin
    int n;
    doReset();

    $display("[TB] full-scale word with CRLF");
    sendText("3FFFF");
    sendByte(8'h0D);
    sendByte(8'h0A);
    drain();
    checkOutput("t1_err_count", 32'(err_count), 0);

    $display("[TB] consumer stalls held word");
    stall_len = 10;
    sendText("2a\n0007\n");
    drain();
    stall_len = 0;

    $display("[TB] oversized lines");
    sendText("40000\n");
    drain();
    checkOutput("t3_err_count1", 32'(err_count), 1);
    sendText("123456\n");
    drain();
    checkOutput("t3_err_count2", 32'(err_count), 2);

    $display("[TB] illegal character recovery");
    sendText("12G4\n5\n");
    drain();

    $display("[TB] separators and mid-line reset");
    sendText("1 2\t3\n");
    drain();
    sendText("AB");
    n = 0;
    while (tx_q.size() > 0 && n < 200) begin
      applyStimulus();
      n++;
    end
    checkOutput("ab_sent", 32'(tx_q.size()), 0);
    applyStimulus();
    checkOutput("busy_midline", 32'(busy), 1);
    doReset();
    sendText("C\n");
    drain();

`ifdef JTAG_HEX_RX_ECHO_EN
    $display("[TB] echo sink stall");
    echo_hold = 3;
    sendText("5\n");
    drain();
`endif

    $display("[TB] random lines");
    repeat (80) randomLine();
    drain();

    $display("[TB] error counter saturation");
    repeat (260) sendText("G\n");
    drain();
    checkOutput("sat_err_count", 32'(err_count), 255);
    checkOutput("busy_end", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
